// File: rtl/bsg_arb_rr_lock.sv
// Round-robin arbiter with grant locking and a registered rotating priority pointer.
// Optional hold timeout enabled by defining BSG_ARB_RR_LOCK_MAX_HOLD_EN.
module bsg_arb_rr_lock #(
    parameter int unsigned inputs_p   = 4,
    parameter bit          lo_to_hi_p = 1'b1,
    parameter int unsigned max_hold_p = 16
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          ready_i,
    input  logic [inputs_p-1:0]                           reqs_i,
    input  logic                                          lock_i,
    output logic [inputs_p-1:0]                           grants_o,
    output logic [((inputs_p > 1) ? $clog2(inputs_p) : 1)-1:0] grant_id_o,
    output logic                                          v_o,
    output logic                                          locked_o,
    output logic                                          timeout_o
);

    localparam int unsigned id_w = (inputs_p > 1) ? $clog2(inputs_p) : 1;
    // Pointer reset so the first search lands on index 0 (up) or inputs_p-1 (down).
    localparam logic [id_w-1:0] ptr_init = lo_to_hi_p ? id_w'(inputs_p - 1) : '0;

    if (inputs_p < 1 || max_hold_p < 1) begin : g_param_check
        $error("bsg_arb_rr_lock: inputs_p and max_hold_p must be >= 1");
    end

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_e;

    state_e          state_r;
    logic [id_w-1:0] ptr_r;
    logic [id_w-1:0] owner_r;
    logic [id_w-1:0] winner;
    logic            winner_v;
    logic [id_w-1:0] grant_id;
    logic            grant_v;
    logic            rel_fire;

    always_comb begin
        int unsigned idx;
        winner   = '0;
        winner_v = 1'b0;
        idx      = 0;
        for (int unsigned i = 1; i <= inputs_p; i++) begin
            if (lo_to_hi_p)
                idx = (32'(ptr_r) + i) % inputs_p;
            else
                idx = (32'(ptr_r) + inputs_p - i) % inputs_p;
            if (!winner_v && reqs_i[id_w'(idx)]) begin
                winner   = id_w'(idx);
                winner_v = 1'b1;
            end
        end
    end

    always_comb begin
        grant_v  = 1'b0;
        grant_id = '0;
        if (!reset_i && ready_i) begin
            if (state_r == ST_LOCKED) begin
                grant_v  = reqs_i[owner_r];
                grant_id = owner_r;
            end else begin
                grant_v  = winner_v;
                grant_id = winner;
            end
        end
        if (!grant_v)
            grant_id = '0;
    end

    always_comb begin
        grants_o = '0;
        for (int unsigned i = 0; i < inputs_p; i++)
            grants_o[i] = grant_v && (grant_id == id_w'(i));
    end

    assign v_o        = grant_v;
    assign grant_id_o = grant_id;
    assign locked_o   = (state_r == ST_LOCKED);
    assign rel_fire   = grant_v && !lock_i;

`ifdef BSG_ARB_RR_LOCK_MAX_HOLD_EN
    localparam int unsigned hold_w = $clog2(max_hold_p + 1);
    localparam logic [hold_w-1:0] hold_last = hold_w'(max_hold_p - 1);

    logic [hold_w-1:0] hold_r;
    logic              timeout_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= ST_UNLOCKED;
            ptr_r     <= ptr_init;
            owner_r   <= '0;
            hold_r    <= '0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                ST_UNLOCKED: begin
                    if (grant_v) begin
                        ptr_r <= grant_id;
                        if (lock_i) begin
                            state_r <= ST_LOCKED;
                            owner_r <= grant_id;
                            hold_r  <= '0;
                        end
                    end
                end
                default: begin
                    hold_r <= hold_r + 1'b1;
                    if (grant_v)
                        ptr_r <= owner_r;
                    // A release fire on the last hold cycle is an ordinary release, not a timeout.
                    if (rel_fire) begin
                        state_r <= ST_UNLOCKED;
                    end else if (hold_r == hold_last) begin
                        state_r   <= ST_UNLOCKED;
                        ptr_r     <= owner_r;
                        timeout_r <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign timeout_o = timeout_r;
`else
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_UNLOCKED;
            ptr_r   <= ptr_init;
            owner_r <= '0;
        end else begin
            case (state_r)
                ST_UNLOCKED: begin
                    if (grant_v) begin
                        ptr_r <= grant_id;
                        if (lock_i) begin
                            state_r <= ST_LOCKED;
                            owner_r <= grant_id;
                        end
                    end
                end
                default: begin
                    if (grant_v)
                        ptr_r <= owner_r;
                    if (rel_fire)
                        state_r <= ST_UNLOCKED;
                end
            endcase
        end
    end

    assign timeout_o = 1'b0;
`endif

endmodule
